// File: rtl/ccd_capture_pkg.sv
// Shared types, widths and helpers for the ccd_capture sensor front end.
package ccd_capture_pkg;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned COORD_W     = 16;
    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned DEF_WIDTH   = 1280;
    localparam int unsigned DEF_HEIGHT  = 960;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Test pattern pixel: low six bits of the line above low six bits of the column.
    function automatic logic [DATA_W-1:0] pattern_pix(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        return {y[5:0], x[5:0]};
    endfunction

endpackage

// File: rtl/ccd_capture_if.sv
// Sensor/control inputs and the pixel stream toward imgproc.
interface ccd_capture_if;

    logic [ccd_capture_pkg::DATA_W-1:0]      sensor_data;
    logic                                    fval;
    logic                                    lval;
    logic                                    start;
    logic                                    stop;
    logic                                    pattern_sel;

    logic [ccd_capture_pkg::DATA_W-1:0]      pix_data;
    logic                                    dval;
    logic [ccd_capture_pkg::COORD_W-1:0]     x_cont;
    logic [ccd_capture_pkg::COORD_W-1:0]     y_cont;
    logic [ccd_capture_pkg::FRAME_CNT_W-1:0] frame_cont;

    modport master (
        output sensor_data, fval, lval, start, stop, pattern_sel,
        input  pix_data, dval, x_cont, y_cont, frame_cont
    );

    modport slave (
        input  sensor_data, fval, lval, start, stop, pattern_sel,
        output pix_data, dval, x_cont, y_cont, frame_cont
    );

endinterface

// File: rtl/ccd_xy_counter.sv
// Column/line counters: accept qualification, column hold at WIDTH, line saturation at HEIGHT.
module ccd_xy_counter
    import ccd_capture_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               f,
    input  logic               l,
    input  logic               lvf,
    input  logic               clear,
    output logic               accept_c,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    logic x_room;
    logic y_room;

    assign x_room   = (x < COORD_W'(WIDTH));
    assign y_room   = (y < COORD_W'(HEIGHT));
    assign accept_c = en & f & l & x_room & y_room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (lvf) begin
                x <= '0;
                if (y_room) begin
                    y <= y + COORD_W'(1);
                end
            end else if (accept_c) begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccd_capture.sv
// Raw sensor capture: whole-frame start/stop gating, X/Y tagging and frame counting.
// Optional CCD_CAPTURE_PATTERN_EN replaces sensor data with a coordinate test pattern.
module ccd_capture
    import ccd_capture_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input logic          clk,
    input logic          rst_n,
    ccd_capture_if.slave bus
);

    logic [DATA_W-1:0]      d;
    logic                   f, l, f_d, l_d;
    logic                   start_q, stop_q;
    logic                   fvr, fvf, lvf;

    cap_state_e             state, state_nxt;
    logic                   stop_req;
    logic                   xy_clear_c, capture_c, frame_done_c, stop_set_c;

    logic                   accept_c;
    logic [COORD_W-1:0]     x, y;
    logic [DATA_W-1:0]      pix_sel_c;

    logic [DATA_W-1:0]      data_q;
    logic                   dval_q;
    logic [COORD_W-1:0]     x_q, y_q;
    logic [FRAME_CNT_W-1:0] frame_q;

    // Input stage with delayed strobes for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d       <= '0;
            f       <= 1'b0;
            l       <= 1'b0;
            f_d     <= 1'b0;
            l_d     <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            d       <= bus.sensor_data;
            f       <= bus.fval;
            l       <= bus.lval;
            f_d     <= f;
            l_d     <= l;
            start_q <= bus.start;
            stop_q  <= bus.stop;
        end
    end

    assign fvr = f & ~f_d;
    assign fvf = ~f & f_d;
    assign lvf = ~l & l_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop wins over start; a running frame always completes before leaving CAPTURE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (stop_q) begin
                    state_nxt = IDLE;
                end else if (start_q) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (stop_q) begin
                    state_nxt = IDLE;
                end else if (fvr) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (fvf) begin
                    state_nxt = (stop_req | stop_q) ? IDLE : ARMED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        xy_clear_c   = 1'b0;
        capture_c    = 1'b0;
        frame_done_c = 1'b0;
        stop_set_c   = 1'b0;
        case (state)
            ARMED: begin
                xy_clear_c = fvr & ~stop_q;
            end
            CAPTURE: begin
                capture_c    = 1'b1;
                frame_done_c = fvf;
                stop_set_c   = stop_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_req <= 1'b0;
        end else if (frame_done_c) begin
            stop_req <= 1'b0;
        end else if (stop_set_c) begin
            stop_req <= 1'b1;
        end
    end

    ccd_xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_xy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (capture_c),
        .f        (f),
        .l        (l),
        .lvf      (lvf),
        .clear    (xy_clear_c),
        .accept_c (accept_c),
        .x        (x),
        .y        (y)
    );

`ifdef CCD_CAPTURE_PATTERN_EN
    logic pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 1'b0;
        end else begin
            pat_q <= bus.pattern_sel;
        end
    end

    assign pix_sel_c = pat_q ? pattern_pix(x, y) : d;
`else
    logic unused_pattern;

    assign unused_pattern = bus.pattern_sel;
    assign pix_sel_c      = d;
`endif

    // Output stage: data and coordinates hold between accepted pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dval_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            dval_q <= accept_c;
            if (accept_c) begin
                data_q <= pix_sel_c;
                x_q    <= x;
                y_q    <= y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (frame_done_c) begin
            frame_q <= frame_q + FRAME_CNT_W'(1);
        end
    end

    assign bus.pix_data   = data_q;
    assign bus.dval       = dval_q;
    assign bus.x_cont     = x_q;
    assign bus.y_cont     = y_q;
    assign bus.frame_cont = frame_q;

endmodule

// File: tb/tb_ccd_capture.sv
// Randomized bench for ccd_capture against a frame-level capture model.
module tb_ccd_capture;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic  clk = 1'b0;
    logic  rst_n;
    longint cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: 0 = idle, 1 = armed for the next frame start
    int          m_state  = 0;
    bit          m_stop   = 0;
    logic [31:0] m_frames = '0;

    logic [43:0] exp_q[$];
    longint      dcyc_q[$];
    logic [43:0] mon_e;
    longint      mon_dc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ccd_capture_if bus();

    ccd_capture #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every output pixel: latency from drive, data, column and line
    always @(negedge clk) begin
        if (rst_n && bus.dval) begin
            if (exp_q.size() == 0) begin
                check("spurious_dval", 64'(bus.dval), 64'(0));
            end else begin
                mon_e  = exp_q.pop_front();
                mon_dc = dcyc_q.pop_front();
                check("pix", {8'(cyc - mon_dc), bus.pix_data, bus.x_cont, bus.y_cont},
                      {8'd2, mon_e});
            end
        end
    end

    function automatic logic [11:0] exp_data(input logic [11:0] dv, input bit pat,
                                             input int x, input int y);
`ifdef CCD_CAPTURE_PATTERN_EN
        if (pat) return 12'(((y % 64) * 64) + (x % 64));
`endif
        return dv;
    endfunction

    // Control pulse while the sensor is between frames; ctl bit0 = start, bit1 = stop
    task automatic gap_ctl(input int ctl);
        tick($urandom_range(2, 5));
        if (ctl != 0) begin
            bus.start = ctl[0];
            bus.stop  = ctl[1];
            tick();
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (ctl[1]) m_state = 0;
            else        m_state = 1;
        end
        tick(4);
    endtask

    // One sensor frame; mid_ctl 1 = start pulse, 2 = stop pulse after the first line
    task automatic run_frame(input int n_lines, input int line_len, input int mid_ctl,
                             input bit pat, input bit seq_data);
        bit          capt;
        logic [11:0] dv;
        capt   = (m_state == 1);
        m_stop = 0;
        bus.pattern_sel = pat;
        bus.fval = 1'b1;
        tick($urandom_range(2, 4));
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < line_len; x++) begin
                dv = seq_data ? 12'(12'h100 + y * line_len + x) : 12'($urandom);
                bus.sensor_data = dv;
                bus.lval = 1'b1;
                if (capt && x < int'(W) && y < int'(H)) begin
                    exp_q.push_back({exp_data(dv, pat, x, y), 16'(x), 16'(y)});
                    dcyc_q.push_back(cyc);
                end
                tick();
            end
            bus.lval = 1'b0;
            tick($urandom_range(1, 3));
            if (y == 0 && mid_ctl != 0) begin
                bus.start = (mid_ctl == 1);
                bus.stop  = (mid_ctl == 2);
                tick();
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                tick(2);
                if (capt) begin
                    if (mid_ctl == 2) m_stop = 1;
                end else begin
                    m_state = (mid_ctl == 1) ? 1 : 0;
                end
            end
        end
        tick(2);
        bus.fval = 1'b0;
        tick(3);
        if (capt) begin
            m_frames = m_frames + 32'd1;
            m_state  = m_stop ? 0 : 1;
        end
        check("frame_cont", 64'(bus.frame_cont), 64'(m_frames));
    endtask

    task automatic check_zero_outputs(input string phase);
        check({phase, "_data"},   64'(bus.pix_data),   64'(0));
        check({phase, "_dval"},   64'(bus.dval),       64'(0));
        check({phase, "_x"},      64'(bus.x_cont),     64'(0));
        check({phase, "_y"},      64'(bus.y_cont),     64'(0));
        check({phase, "_frames"}, 64'(bus.frame_cont), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.sensor_data = '0;
        bus.fval = 1'b0;
        bus.lval = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pattern_sel = 1'b0;
        tick(3);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        tick(2);

        // Full 4x8 frame with sequential data
        gap_ctl(1);
        run_frame(4, 8, 0, 0, 1);

        // Start while FVAL is high: that frame is skipped, the next one captured
        gap_ctl(2);
        run_frame(3, 6, 1, 0, 0);
        run_frame(4, 8, 0, 0, 0);

        // Stop during a captured frame: frame finishes, next frame ignored
        run_frame(4, 8, 2, 0, 0);
        run_frame(4, 8, 0, 0, 0);

        // Oversize lines and frame
        gap_ctl(1);
        run_frame(5, 10, 0, 0, 0);

        // Start and stop together while armed/idle: stop wins
        gap_ctl(2);
        gap_ctl(3);
        run_frame(2, 5, 0, 0, 0);

        // Test pattern
        gap_ctl(1);
        run_frame(4, 8, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            gap_ctl($urandom_range(0, 3));
            run_frame($urandom_range(1, 6), $urandom_range(1, 11), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of a captured frame
        gap_ctl(1);
        bus.pattern_sel = 1'b0;
        bus.fval = 1'b1;
        tick(3);
        for (int x = 0; x < 8; x++) begin
            bus.sensor_data = 12'($urandom);
            bus.lval = 1'b1;
            exp_q.push_back({bus.sensor_data, 16'(x), 16'(0)});
            dcyc_q.push_back(cyc);
            tick();
        end
        bus.lval = 1'b0;
        tick(4);
        rst_n = 1'b0;
        m_state  = 0;
        m_frames = '0;
        tick(2);
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        tick(2);
        for (int y = 1; y < 3; y++) begin
            for (int x = 0; x < 8; x++) begin
                bus.sensor_data = 12'($urandom);
                bus.lval = 1'b1;
                tick();
            end
            bus.lval = 1'b0;
            tick(2);
        end
        bus.fval = 1'b0;
        tick(3);
        check("postrst_frames", 64'(bus.frame_cont), 64'(0));
        run_frame(4, 8, 0, 0, 0);
        gap_ctl(1);
        run_frame(4, 8, 0, 0, 0);

        tick(5);
        check("pix_left", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccd_capture.md
# ccd_capture

Front end of the camera pipeline: turns the raw sensor stream (frame/line valid strobes plus 12-bit Bayer data) into the pixel stream that imgproc consumes. The stream carries data, data-valid and X/Y pixel coordinates. Capture is gated by start/stop controls, and only whole frames are captured. Completed frames are counted. An optional generated test pattern can replace the sensor data.

## Interface
- WIDTH, 1280: active pixels per line; X counts 0..WIDTH-1.
- HEIGHT, 960: active lines per frame; Y counts 0..HEIGHT-1.
- iCLK  in  1  pixel clock; all logic is on its rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iDATA  in  12  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iSTART  in  1  level/pulse; arms capture.
- iEND  in  1  level/pulse; requests stop.
- iPATTERN  in  1  selects the test pattern (only when CCD_CAPTURE_PATTERN_EN is defined).
- oDATA  out  12  pixel to imgproc.
- oDVAL  out  1  oDATA/oX_Cont/oY_Cont are valid this cycle.
- oX_Cont  out  16  column of the current pixel.
- oY_Cont  out  16  line of the current pixel.
- oFrame_Cont  out  32  count of completed captured frames; wraps at 2^32.

## Operation
- Stage 1 registers iDATA, iFVAL and iLVAL as d, f and l, plus delayed copies f_d and l_d for edge detection.
- fvr = f & !f_d (FVAL rising); fvf = !f & f_d (FVAL falling); lvf = !l & l_d (LVAL falling).
- State IDLE:
  - iSTART=1 -> ARMED.
  - iEND takes priority when iSTART and iEND are both high in the same cycle.
- State ARMED:
  - fvr -> CAPTURE; X and Y clear to 0.
  - iEND -> IDLE.
  - If FVAL is already high when arming, wait for the next fvr. No partial frames.
- State CAPTURE:
  - iEND sets a sticky stop_req; the current frame is always finished.
  - On fvf: oFrame_Cont increments. Then IDLE if stop_req (stop_req clears), else ARMED.
- Counters in CAPTURE:
  - Each cycle with f & l and X<WIDTH: a pixel is accepted, then X increments.
  - When X reaches WIDTH it holds; further pixels on that line are dropped.
  - On lvf: X clears to 0 and Y increments, saturating at HEIGHT. Lines received while Y=HEIGHT are dropped.
- Short lines and short frames are passed through unchanged. There is no padding.
- Output stage registers the accepted pixel: oDVAL=1, oDATA=d, oX_Cont/oY_Cont = the X/Y before increment. Otherwise oDVAL=0 and the other outputs hold their last values.
- Reset, including mid-frame, clears state to IDLE, clears every output and counter, and clears stop_req. A new iSTART is required after reset.

## Timing
- Reset values: oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0, oFrame_Cont=0.
- Latency: a pixel sampled on iDATA at edge n appears on oDATA at edge n+2, with oDVAL and coordinates aligned to it.
- An iSTART sampled at edge n arms at edge n+1. An fvr then needs the sensor's FVAL high 2 edges after arming. There is no minimum iSTART/iEND width beyond one cycle.
- oDVAL has no back-pressure. The downstream block must accept one pixel per cycle.
- oFrame_Cont updates one cycle after fvf is detected.

## Configuration
- Macro: CCD_CAPTURE_PATTERN_EN.
- When defined and iPATTERN=1: oDATA = {Y[5:0], X[5:0]} from the accepted pixel's coordinates, and the sensor data is ignored. Timing and oDVAL are unchanged.
- When not defined: the iPATTERN port exists but is ignored, and oDATA is always the sensor data.

## Structure
- Package ccd_capture_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE};
  - default WIDTH/HEIGHT localparams;
  - coordinate width constant (16);
  - pattern function (x,y) -> 12-bit.
- One sub-module, ccd_xy_counter, owns X/Y accept, saturate and clear logic. It takes f, l, lvf and a clear input, and returns accept, X and Y.

## Test plan
- Reset held low mid-frame, then released -> all outputs 0, state IDLE, no oDVAL until a new iSTART plus fvr.
- WIDTH=8, HEIGHT=4; iSTART, then a frame of 4 lines x 8 pixels with iDATA=12'h100+index -> 32 oDVAL pulses. First pulse has oDATA=12'h100 at 2 cycles after input, X=0, Y=0. Last pulse has X=7, Y=3. oFrame_Cont=1 after FVAL falls.
- iSTART while FVAL is already high mid-frame -> no oDVAL for that frame; capture begins on the next frame with X=0, Y=0.
- iEND pulsed at line 2 of a frame -> the frame completes (all 32 pixels), oFrame_Cont increments, state becomes IDLE, and the next frame produces no oDVAL.
- Line of 10 pixels with WIDTH=8, and 5 lines with HEIGHT=4 -> only X 0..7 and Y 0..3 are output; extra pixels and lines are dropped.
- With CCD_CAPTURE_PATTERN_EN and iPATTERN=1, pixel at X=5, Y=2 -> oDATA=12'h085, regardless of iDATA.
